multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter CHANNELS, default 4: number of independent button channels, range 1..32.
REQ-003 Parameter CNT_W, default 22: width of each per-channel dead-time counter.
REQ-004 Parameter DEAD_TIME, default 3000000: hold-off length in Clk cycles, range 1..2^CNT_W-1; out-of-range values SHALL be an elaboration error.
REQ-005 Parameter SYNC_STAGES, default 2: synchroniser depth per channel, range 2..4.
REQ-006 Port Clk  input  1  system clock; all state changes on rising edge.
REQ-007 Port nReset  input  1  synchronous active-low reset.
REQ-008 Port Button  input  CHANNELS  raw asynchronous button levels.
REQ-009 Port State  output  CHANNELS  debounced level per channel, registered.
REQ-010 Port Rise  output  CHANNELS  one-cycle pulse when State goes 0->1.
REQ-011 Port Fall  output  CHANNELS  one-cycle pulse when State goes 1->0.
REQ-012 Port Busy  output  CHANNELS  high while the channel's counter is running.

Function
REQ-013 Each channel SHALL pass Button[i] through a SYNC_STAGES-deep flop chain; only the last stage (S[i]) feeds channel logic.
REQ-014 Channels SHALL be fully independent; activity on one SHALL never alter another's outputs or timing.
REQ-015 Each channel SHALL run a two-state FSM: IDLE and HOLD (lockout mode).
REQ-016 IDLE: if S[i] != State[i], then on that edge State[i] <= S[i], counter <= 0, Busy[i] <= 1, FSM -> HOLD.
REQ-017 Rise[i]/Fall[i] SHALL assert for exactly the one cycle following the edge that updates State[i]; they SHALL never both be high.
REQ-018 HOLD: counter SHALL increment by 1 per cycle; S[i] changes SHALL be ignored.
REQ-019 HOLD: on the edge where counter == DEAD_TIME-1, FSM -> IDLE, counter <= 0, Busy[i] <= 0; Busy[i] is thus high for exactly DEAD_TIME cycles.
REQ-020 On the first IDLE cycle after HOLD, a pending S[i] != State[i] SHALL be accepted immediately (REQ-016).
REQ-021 The counter SHALL never wrap; it is held at 0 in IDLE.
REQ-022 Latency: a Button level first sampled at edge N SHALL update State at edge N+SYNC_STAGES when the channel is IDLE.

Reset
REQ-023 While nReset is low at a rising edge: sync flops, State, Rise, Fall, Busy and all counters SHALL be 0, and every FSM SHALL be IDLE.
REQ-024 Reset asserted mid-HOLD SHALL abort the hold with no Rise/Fall pulse generated.
REQ-025 A Button held high through reset release SHALL be reported as a Rise after synchroniser latency, with no extra hold-off.

Configuration
REQ-026 Macro DEBOUNCE_STABLE_EN SHALL select the filter mode at compile time.
REQ-027 Without DEBOUNCE_STABLE_EN: lockout mode per REQ-015..REQ-021 (accept first edge, then ignore for DEAD_TIME cycles).
REQ-028 With DEBOUNCE_STABLE_EN: counter runs while S[i] != State[i] and clears to 0 on any cycle S[i] == State[i]. State[i] <= S[i] on the edge where the counter equals DEAD_TIME-1 with S[i] still differing; the counter then clears. Busy[i] SHALL be high while counting.
REQ-029 Rise/Fall and reset behaviour SHALL be identical in both modes.

Verification (CHANNELS=4, DEAD_TIME=8, SYNC_STAGES=2)
REQ-030 Lockout: Button[0] 0->1 sampled at edge 10 -> State[0]=1 and Rise[0]=1 after edge 12; Rise[0] low after edge 13; Busy[0] high for 8 cycles.
REQ-031 Bounce: Button[0] toggles 1,0,1,0 every cycle from edge 13 -> no Fall[0]; State[0] stays 1 until HOLD ends. The final level is then accepted at once.
REQ-032 Independence: Button[1] and Button[3] rise on the same edge -> both Rise pulses fire on the same cycle; channels 0 and 2 stay quiet.
REQ-033 Reset mid-HOLD: nReset low at edge 15 with Busy[2]=1 -> all outputs 0 after edge 15; no pulses during or after reset.
REQ-034 DEBOUNCE_STABLE_EN: Button[0] high for 5 cycles, low 1, then high 10 -> single Rise[0], 8 cycles after the last restart of the counter.
REQ-035 Boundary: DEAD_TIME=1 -> Busy high exactly one cycle; back-to-back opposite edges accepted on consecutive IDLE opportunities.

Source files
------------

// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - per-channel button debouncer: sync chain, registered State and Rise/Fall pulses, Busy hold-off.
// Define DEBOUNCE_STABLE_EN for stable-level filtering; the default build is first-edge lockout.
module multi_debounce #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 22,
    parameter int DEAD_TIME   = 3000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic [CHANNELS-1:0] Button,
    output logic [CHANNELS-1:0] State,
    output logic [CHANNELS-1:0] Rise,
    output logic [CHANNELS-1:0] Fall,
    output logic [CHANNELS-1:0] Busy
);

    localparam longint MAX_DT = (longint'(1) << CNT_W) - longint'(1);
    localparam logic [CNT_W-1:0] DT_M1 = CNT_W'(DEAD_TIME - 1);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("multi_debounce: CHANNELS must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("multi_debounce: SYNC_STAGES must be 2..4");
    end
    if (DEAD_TIME < 1 || longint'(DEAD_TIME) > MAX_DT) begin : g_bad_dead_time
        $error("multi_debounce: DEAD_TIME must be 1..2^CNT_W-1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } fsm_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        fsm_t                   fsm;
        logic [CNT_W-1:0]       cnt;
        logic                   state_q;
        logic                   rise_q;
        logic                   fall_q;

        assign s = sync[SYNC_STAGES-1];

        always_ff @(posedge Clk) begin
            if (!nReset) begin
                sync    <= '0;
                fsm     <= IDLE;
                cnt     <= '0;
                state_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync   <= {sync[SYNC_STAGES-2:0], Button[i]};
                rise_q <= 1'b0;
                fall_q <= 1'b0;
`ifdef DEBOUNCE_STABLE_EN
                // HOLD here means "a differing level is being timed"; any agreeing cycle restarts it.
                if (s != state_q) begin
                    if (cnt == DT_M1) begin
                        state_q <= s;
                        rise_q  <= s;
                        fall_q  <= state_q;
                        cnt     <= '0;
                        fsm     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        fsm <= HOLD;
                    end
                end else begin
                    cnt <= '0;
                    fsm <= IDLE;
                end
`else
                if (fsm == IDLE) begin
                    if (s != state_q) begin
                        state_q <= s;
                        rise_q  <= s;
                        fall_q  <= state_q;
                        cnt     <= '0;
                        fsm     <= HOLD;
                    end
                end else begin
                    if (cnt == DT_M1) begin
                        cnt <= '0;
                        fsm <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
            end
        end

        assign State[i] = state_q;
        assign Rise[i]  = rise_q;
        assign Fall[i]  = fall_q;
        assign Busy[i]  = (fsm == HOLD);
    end

endmodule

// File: tb/tb_multi_debounce.sv
// tb/tb_multi_debounce.sv - randomized bench for multi_debounce (DEAD_TIME 8 and 1) against a timestamp model.
module tb_multi_debounce;
    localparam int CH    = 4;
    localparam int SYNC  = 2;
    localparam int EDGES = 3000;

    logic          clk = 1'b0;
    logic          nreset;
    logic [CH-1:0] button;
    logic [CH-1:0] state_a, rise_a, fall_a, busy_a;
    logic [CH-1:0] state_b, rise_b, fall_b, busy_b;

    always #5 clk = ~clk;

    multi_debounce #(.CHANNELS(CH), .CNT_W(22), .DEAD_TIME(8), .SYNC_STAGES(SYNC)) u_dut_a (
        .Clk(clk), .nReset(nreset), .Button(button),
        .State(state_a), .Rise(rise_a), .Fall(fall_a), .Busy(busy_a)
    );

    multi_debounce #(.CHANNELS(CH), .CNT_W(2), .DEAD_TIME(1), .SYNC_STAGES(SYNC)) u_dut_b (
        .Clk(clk), .nReset(nreset), .Button(button),
        .State(state_b), .Rise(rise_b), .Fall(fall_b), .Busy(busy_b)
    );

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // Model: button level sampled at every edge; a channel sees the level from SYNC edges ago.
    logic [CH-1:0] btn_at [0:EDGES];
    logic          m_state [2][CH];
    logic          m_rise  [2][CH];
    logic          m_fall  [2][CH];
    int            m_end   [2][CH];
    int            m_run   [2][CH];

    function automatic int dt_of(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    task automatic accept(input int k, input int c, input logic s);
        m_rise[k][c]  = s;
        m_fall[k][c]  = m_state[k][c];
        m_state[k][c] = s;
    endtask

    task automatic model_step(input int e, input logic rn, input logic [CH-1:0] b);
        logic s;
        if (!rn) begin
            for (int j = 0; j < SYNC; j++)
                if (e - j >= 0) btn_at[e-j] = '0;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < CH; c++) begin
                    m_state[k][c] = 1'b0;
                    m_rise[k][c]  = 1'b0;
                    m_fall[k][c]  = 1'b0;
                    m_end[k][c]   = e;
                    m_run[k][c]   = 0;
                end
        end else begin
            btn_at[e] = b;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < CH; c++) begin
                    s = (e >= SYNC) ? btn_at[e-SYNC][c] : 1'b0;
                    m_rise[k][c] = 1'b0;
                    m_fall[k][c] = 1'b0;
`ifdef DEBOUNCE_STABLE_EN
                    if (s != m_state[k][c]) begin
                        m_run[k][c]++;
                        if (m_run[k][c] == dt_of(k)) begin
                            accept(k, c, s);
                            m_run[k][c] = 0;
                        end
                    end else begin
                        m_run[k][c] = 0;
                    end
`else
                    if (e > m_end[k][c] && s != m_state[k][c]) begin
                        accept(k, c, s);
                        m_end[k][c] = e + dt_of(k);
                    end
`endif
                end
        end
    endtask

    function automatic logic [CH-1:0] exp_vec(input int k, input int what);
        logic [CH-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++)
            case (what)
                0: v[c] = m_state[k][c];
                1: v[c] = m_rise[k][c];
                2: v[c] = m_fall[k][c];
`ifdef DEBOUNCE_STABLE_EN
                default: v[c] = (m_run[k][c] > 0);
`else
                default: v[c] = (n < m_end[k][c]);
`endif
            endcase
        return v;
    endfunction

    task automatic drive(input int e);
        if (e < 80) begin
            nreset    = !(e <= 3 || e == 65 || e == 66);
            button[0] = (e >= 10 && e <= 13) || e == 15;
            button[1] = (e >= 40 && e < 50);
            button[3] = (e >= 40 && e < 50);
            button[2] = (e >= 60);
        end else begin
            nreset = ($urandom_range(0, 299) != 0);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) button[c] = ~button[c];
        end
    endtask

    initial begin
        nreset = 1'b0;
        button = '0;
        for (int e = 1; e <= EDGES; e++) begin
            drive(e);
            @(posedge clk);
            n = e;
            model_step(e, nreset, button);
            @(negedge clk);
            check("state_a", state_a, exp_vec(0, 0));
            check("rise_a",  rise_a,  exp_vec(0, 1));
            check("fall_a",  fall_a,  exp_vec(0, 2));
            check("busy_a",  busy_a,  exp_vec(0, 3));
            check("state_b", state_b, exp_vec(1, 0));
            check("rise_b",  rise_b,  exp_vec(1, 1));
            check("fall_b",  fall_b,  exp_vec(1, 2));
            check("busy_b",  busy_b,  exp_vec(1, 3));
            check("rise_fall_excl", rise_a & fall_a, 0);
            if (e == 3) check("reset_outputs", {state_a, rise_a, fall_a, busy_a}, 0);
`ifndef DEBOUNCE_STABLE_EN
            if (e == 12) begin
                check("lock_state_set", state_a[0], 1);
                check("lock_rise",      rise_a[0], 1);
                check("dt1_busy_on",    busy_b[0], 1);
            end
            if (e == 13) begin
                check("lock_rise_end", rise_a[0], 0);
                check("lock_busy",     busy_a[0], 1);
                check("dt1_busy_off",  busy_b[0], 0);
            end
            if (e == 16) check("dt1_fall", fall_b[0], 1);
            if (e == 19) check("lock_busy_last", {state_a[0], busy_a[0]}, 2'b11);
            if (e == 20) check("lock_busy_done", {state_a[0], busy_a[0], fall_a[0]}, 3'b100);
            if (e == 21) check("lock_pending_fall", {state_a[0], fall_a[0]}, 2'b01);
            if (e == 42) check("indep_rise", rise_a, 4'b1010);
            if (e == 64) check("hold_before_reset", busy_a[2], 1);
            if (e == 65) check("reset_mid_hold", {state_a, rise_a, fall_a, busy_a}, 0);
            if (e == 66) check("reset_no_pulse", {rise_a, fall_a}, 0);
            if (e == 67) check("release_latency", {state_a, rise_a}, 0);
            if (e == 69) check("release_rise", {rise_a, busy_a}, 8'b0100_0100);
`endif
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
